mc_cpu_param: RTL



---
 rtl/mc_cpu_pkg.sv | 32 +++
 rtl/mc_cpu_param_if.sv | 31 +++
 rtl/mc_regfile.sv | 33 +++
 rtl/mc_cpu_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the parametrised multi-cycle MIPS-subset core:
// opcodes, function codes, FSM state values and the imm16 sign-extension helper.
package mc_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] HALT_OP  = 6'b111111;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mc_cpu_param_if.sv
// Host-side bundle of the core: run handshake, program/data load ports and
// the observable status outputs.
interface mc_cpu_param_if #(
  parameter int DATA_W = 8,
  parameter int IA_W   = 4,
  parameter int DA_W   = 4
);
  logic              start;
  logic              imem_we;
  logic [IA_W-1:0]   imem_waddr;
  logic [31:0]       imem_wdata;
  logic              dmem_we;
  logic [DA_W-1:0]   dmem_waddr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] led;
  logic [IA_W-1:0]   pc_out;

  modport master (
    output start, imem_we, imem_waddr, imem_wdata,
    output dmem_we, dmem_waddr, dmem_wdata,
    input  busy, done, led, pc_out
  );

  modport slave (
    input  start, imem_we, imem_waddr, imem_wdata,
    input  dmem_we, dmem_waddr, dmem_wdata,
    output busy, done, led, pc_out
  );
endinterface

// File: rtl/mc_regfile.sv
// 32 x DATA_W register file: two combinational reads, one synchronous write,
// register 0 hardwired to zero, whole array cleared by reset.
module mc_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs_r [32];

  // Register array: cleared on reset, writes to r0 dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (wa != 5'd0)) begin
      regs_r[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? {DATA_W{1'b0}} : regs_r[ra1];
  assign rd2 = (ra2 == 5'd0) ? {DATA_W{1'b0}} : regs_r[ra2];

endmodule

// File: rtl/mc_cpu_param.sv
// Parametrised multi-cycle MIPS-subset core with host load ports, start/done
// handshake and an LED mirror of one architectural register.
module mc_cpu_param #(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  parameter int LED_REG    = 2
) (
  input logic          clk,
  input logic          rst,
  mc_cpu_param_if.slave host
);
  import mc_cpu_pkg::*;

  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);
  localparam logic [4:0]        LED_IDX = 5'(LED_REG);
  localparam logic [DATA_W-1:0] ONE_W   = DATA_W'(1'b1);

  logic [31:0]       imem_r [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_r [DMEM_DEPTH];

  logic [2:0]        state_r, state_nxt_s;
  logic [IA_W-1:0]   pc_r, pc_nxt_s;
  logic [31:0]       ir_r;
  logic [5:0]        op_r, funct_r;
  logic [4:0]        rs_r, rt_r, rd_r;
  logic [DATA_W-1:0] a_r, b_r, imm_r;
  logic [DATA_W-1:0] led_r;
  logic              busy_r, done_r;

  logic [DATA_W-1:0] rf_rd1_s, rf_rd2_s;
  logic              rf_we_s;
  logic [4:0]        rf_wa_s;
  logic [DATA_W-1:0] rf_wd_s;

  logic [DATA_W-1:0] exec_val_s;
  logic              exec_we_s;
  logic [4:0]        exec_wa_s;
  logic [IA_W-1:0]   exec_pc_s;
  logic [DA_W-1:0]   mem_addr_s;
  logic              host_ok_s;

  mc_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (ir_r[25:21]),
    .ra2 (ir_r[20:16]),
    .rd1 (rf_rd1_s),
    .rd2 (rf_rd2_s),
    .we  (rf_we_s),
    .wa  (rf_wa_s),
    .wd  (rf_wd_s)
  );

  assign host_ok_s  = (state_r == IDLE) || (state_r == HALT);
  assign mem_addr_s = DA_W'(a_r + imm_r);

  // Instruction memory: host load port only, no reset
  always_ff @(posedge clk) begin
    if (host.imem_we && host_ok_s) begin
      imem_r[host.imem_waddr] <= host.imem_wdata;
    end
  end

  // Data memory: sw from MEM, otherwise host load while idle or halted
  always_ff @(posedge clk) begin
    if ((state_r == MEM) && (op_r == OP_SW)) begin
      dmem_r[mem_addr_s] <= b_r;
    end else if (host.dmem_we && host_ok_s) begin
      dmem_r[host.dmem_waddr] <= host.dmem_wdata;
    end
  end

  // EXEC datapath: ALU result, write-back target and next pc
  always_comb begin
    exec_val_s = {DATA_W{1'b0}};
    exec_we_s  = 1'b0;
    exec_wa_s  = rd_r;
    exec_pc_s  = pc_r;
    case (op_r)
      OP_RTYPE: begin
        case (funct_r)
          FN_ADDU: begin exec_val_s = a_r + b_r; exec_we_s = 1'b1; end
          FN_SUBU: begin exec_val_s = a_r - b_r; exec_we_s = 1'b1; end
          FN_AND:  begin exec_val_s = a_r & b_r; exec_we_s = 1'b1; end
          FN_OR:   begin exec_val_s = a_r | b_r; exec_we_s = 1'b1; end
          FN_SLT: begin
            exec_val_s = ($signed(a_r) < $signed(b_r)) ? ONE_W : {DATA_W{1'b0}};
            exec_we_s  = 1'b1;
          end
          FN_JR:   exec_pc_s = IA_W'(a_r);
          default: exec_we_s = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        exec_val_s = a_r + imm_r;
        exec_wa_s  = rt_r;
        exec_we_s  = 1'b1;
      end
      // Branch offset is applied to the already-incremented pc and wraps in IA_W bits
      OP_BEQ: begin
        if (a_r == b_r) exec_pc_s = pc_r + IA_W'(ir_r[15:0]);
        else            exec_pc_s = pc_r;
      end
      OP_BNE: begin
        if (a_r != b_r) exec_pc_s = pc_r + IA_W'(ir_r[15:0]);
        else            exec_pc_s = pc_r;
      end
      OP_J:    exec_pc_s = IA_W'(ir_r[25:0]);
      default: exec_we_s = 1'b0;
    endcase
  end

  // Register-file write port: ALU results in EXEC, load data in MEM
  always_comb begin
    rf_we_s = 1'b0;
    rf_wa_s = exec_wa_s;
    rf_wd_s = exec_val_s;
    if (state_r == EXEC) begin
      rf_we_s = exec_we_s;
    end else if ((state_r == MEM) && (op_r == OP_LW)) begin
      rf_we_s = 1'b1;
      rf_wa_s = rt_r;
      rf_wd_s = dmem_r[mem_addr_s];
    end else begin
      rf_we_s = 1'b0;
    end
  end

  // Next-state and next-pc selection
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      IDLE, HALT: begin
        if (host.start) begin
          state_nxt_s = FETCH;
          pc_nxt_s    = {IA_W{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      FETCH: begin
        state_nxt_s = DECODE;
        pc_nxt_s    = pc_r + IA_W'(1'b1);
      end
      DECODE: state_nxt_s = EXEC;
      EXEC: begin
        pc_nxt_s = exec_pc_s;
        if ((op_r == OP_LW) || (op_r == OP_SW)) state_nxt_s = MEM;
        else if (op_r == HALT_OP)               state_nxt_s = HALT;
        else                                    state_nxt_s = FETCH;
      end
      MEM:     state_nxt_s = FETCH;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control state, instruction fields, operands and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pc_r    <= {IA_W{1'b0}};
      ir_r    <= 32'd0;
      op_r    <= 6'd0;
      funct_r <= 6'd0;
      rs_r    <= 5'd0;
      rt_r    <= 5'd0;
      rd_r    <= 5'd0;
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      imm_r   <= {DATA_W{1'b0}};
      led_r   <= {DATA_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      busy_r  <= (state_nxt_s == FETCH) || (state_nxt_s == DECODE) ||
                 (state_nxt_s == EXEC)  || (state_nxt_s == MEM);
      done_r  <= (state_nxt_s == HALT);
      if (state_r == FETCH) begin
        ir_r <= imem_r[pc_r];
      end
      if (state_r == DECODE) begin
        op_r    <= ir_r[31:26];
        rs_r    <= ir_r[25:21];
        rt_r    <= ir_r[20:16];
        rd_r    <= ir_r[15:11];
        funct_r <= ir_r[5:0];
        a_r     <= rf_rd1_s;
        b_r     <= rf_rd2_s;
        imm_r   <= DATA_W'(sext16(ir_r[15:0]));
      end
      if (rf_we_s && (rf_wa_s == LED_IDX) && (rf_wa_s != 5'd0)) begin
        led_r <= rf_wd_s;
      end
    end
  end

  assign host.busy   = busy_r;
  assign host.done   = done_r;
  assign host.led    = led_r;
  assign host.pc_out = pc_r;

endmodule
